// File: rtl/ac_reg_ext_if.sv
// Accumulator bus interface: issue strobe, opcode, operands and status.
// Master drives en/op/din/shamt/sin; slave returns dout and flags.
interface ac_reg_ext_if #(
  parameter int W   = 16,
  parameter int SHW = 5
) ();
  logic           en;
  logic [2:0]     op;
  logic [W-1:0]   din;
  logic [SHW-1:0] shamt;
  logic           sin;
  logic [W-1:0]   dout;
  logic           cout;
  logic           zero;
  logic           neg;
  logic           busy;
  logic           done;

  modport master (
    output en, op, din, shamt, sin,
    input  dout, cout, zero, neg, busy, done
  );

  modport slave (
    input  en, op, din, shamt, sin,
    output dout, cout, zero, neg, busy, done
  );
endinterface

// File: rtl/ac_reg_ext.sv
// Parametrised accumulator with load/clr/inc/dec and multi-cycle shifts.
// Optional macro AC_SAT_EN makes INC/DEC saturate instead of wrapping.
module ac_reg_ext #(
  parameter int W   = 16,
  parameter int SHW = 5
) (
  input logic         clk,
  input logic         rst,
  ac_reg_ext_if.slave bus
);

  typedef enum logic {
    S_IDLE,
    S_SHIFT
  } state_t;

  localparam logic [2:0] OP_NOP  = 3'b000;
  localparam logic [2:0] OP_LOAD = 3'b001;
  localparam logic [2:0] OP_CLR  = 3'b010;
  localparam logic [2:0] OP_INC  = 3'b011;
  localparam logic [2:0] OP_DEC  = 3'b100;
  localparam logic [2:0] OP_SHL  = 3'b101;
  localparam logic [2:0] OP_SAR  = 3'b110;
  localparam logic [2:0] OP_ROR  = 3'b111;

  localparam logic [1:0] SOP_SHL = 2'b01;
  localparam logic [1:0] SOP_SAR = 2'b10;
  localparam logic [1:0] SOP_ROR = 2'b11;

  localparam logic [SHW-1:0] W_MAX = SHW'(W);
  localparam logic [SHW-1:0] C_ONE = SHW'(1);

  state_t         r_state;
  logic [W-1:0]   r_dout;
  logic           r_cout;
  logic [SHW-1:0] r_cnt;
  logic [1:0]     r_sop;
  logic           r_done;

  state_t         w_state_nx;
  logic [W-1:0]   w_dout_nx;
  logic           w_cout_nx;
  logic [SHW-1:0] w_cnt_nx;
  logic [1:0]     w_sop_nx;
  logic           w_done_nx;

  logic [SHW-1:0] w_amt;
  logic [W:0]     w_inc;
  logic [W-1:0]   w_dec;
  logic           w_ones;
  logic           w_is0;
  logic [W-1:0]   w_step;
  logic           w_sbit;

  assign w_amt  = (bus.shamt > W_MAX) ? W_MAX : bus.shamt;
  assign w_inc  = {1'b0, r_dout} + {{W{1'b0}}, 1'b1};
  assign w_dec  = r_dout - {{(W-1){1'b0}}, 1'b1};
  assign w_ones = (r_dout == {W{1'b1}});
  assign w_is0  = (r_dout == {W{1'b0}});

  // One shift/rotate step of the latched shift op; sin is taken live.
  always_comb begin
    w_step = r_dout;
    w_sbit = 1'b0;
    unique case (r_sop)
      SOP_SHL: begin
        w_step = {r_dout[W-2:0], bus.sin};
        w_sbit = r_dout[W-1];
      end
      SOP_SAR: begin
        w_step = {r_dout[W-1], r_dout[W-1:1]};
        w_sbit = r_dout[0];
      end
      SOP_ROR: begin
        w_step = {r_dout[0], r_dout[W-1:1]};
        w_sbit = r_dout[0];
      end
      default: begin
        w_step = r_dout;
        w_sbit = r_cout;
      end
    endcase
  end

  // Next-state and datapath update for the IDLE/SHIFT sequencer.
  always_comb begin
    w_state_nx = r_state;
    w_dout_nx  = r_dout;
    w_cout_nx  = r_cout;
    w_cnt_nx   = r_cnt;
    w_sop_nx   = r_sop;
    w_done_nx  = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (bus.en) begin
          w_done_nx = 1'b1;
          unique case (bus.op)
            OP_NOP: begin
              w_dout_nx = r_dout;
            end
            OP_LOAD: begin
              w_dout_nx = bus.din;
              w_cout_nx = 1'b0;
            end
            OP_CLR: begin
              w_dout_nx = '0;
              w_cout_nx = 1'b0;
            end
            OP_INC: begin
`ifdef AC_SAT_EN
              w_dout_nx = w_ones ? r_dout : w_inc[W-1:0];
              w_cout_nx = w_ones;
`else
              w_dout_nx = w_inc[W-1:0];
              w_cout_nx = w_inc[W];
`endif
            end
            OP_DEC: begin
`ifdef AC_SAT_EN
              w_dout_nx = w_is0 ? r_dout : w_dec;
`else
              w_dout_nx = w_dec;
`endif
              w_cout_nx = w_is0;
            end
            OP_SHL, OP_SAR, OP_ROR: begin
              if (w_amt != '0) begin
                w_done_nx  = 1'b0;
                w_state_nx = S_SHIFT;
                w_cnt_nx   = w_amt;
                w_sop_nx   = bus.op[1:0];
              end
            end
          endcase
        end
      end
      S_SHIFT: begin
        w_dout_nx = w_step;
        w_cout_nx = w_sbit;
        w_cnt_nx  = r_cnt - C_ONE;
        if (r_cnt == C_ONE) begin
          w_state_nx = S_IDLE;
          w_done_nx  = 1'b1;
        end
      end
    endcase
  end

  // State and datapath registers; reset aborts any shift silently.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_dout  <= '0;
      r_cout  <= 1'b0;
      r_cnt   <= '0;
      r_sop   <= 2'b00;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_dout  <= w_dout_nx;
      r_cout  <= w_cout_nx;
      r_cnt   <= w_cnt_nx;
      r_sop   <= w_sop_nx;
      r_done  <= w_done_nx;
    end
  end

  assign bus.dout = r_dout;
  assign bus.cout = r_cout;
  assign bus.zero = w_is0;
  assign bus.neg  = r_dout[W-1];
  assign bus.busy = (r_state == S_SHIFT);
  assign bus.done = r_done;

endmodule

// File: tb/tb_ac_reg_ext.sv
// Directed bench for ac_reg_ext (16-bit default build).
// Expectations follow AC_SAT_EN when it is defined.
module tb_ac_reg_ext;
  logic clk;
  logic rst;
  int   total;
  int   bad;
  int   nb;

  ac_reg_ext_if #(.W(16), .SHW(5)) bus ();

  ac_reg_ext #(.W(16), .SHW(5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [2:0] op,
                       input logic [15:0] d,
                       input logic [4:0] sh);
    bus.en    = 1'b1;
    bus.op    = op;
    bus.din   = d;
    bus.shamt = sh;
    tick();
    bus.en    = 1'b0;
  endtask

  task automatic run_busy(input int lim, output int n);
    n = 0;
    while (bus.busy === 1'b1 && n < lim) begin
      chk("busy_done_excl", {31'd0, bus.done}, 32'd0);
      n++;
      tick();
    end
  endtask

  initial begin
    total     = 0;
    bad       = 0;
    rst       = 1'b1;
    bus.en    = 1'b0;
    bus.op    = 3'b000;
    bus.din   = 16'h0000;
    bus.shamt = 5'd0;
    bus.sin   = 1'b0;
    tick();
    chk("rst_dout", {16'd0, bus.dout}, 32'h0);
    chk("rst_zero", {31'd0, bus.zero}, 32'd1);
    chk("rst_neg",  {31'd0, bus.neg},  32'd0);
    chk("rst_busy", {31'd0, bus.busy}, 32'd0);
    chk("rst_done", {31'd0, bus.done}, 32'd0);
    tick();
    rst = 1'b0;

    issue(3'b001, 16'hA5C3, 5'd0);
    chk("ld_dout", {16'd0, bus.dout}, 32'hA5C3);
    chk("ld_neg",  {31'd0, bus.neg},  32'd1);
    chk("ld_done", {31'd0, bus.done}, 32'd1);
    chk("ld_cout", {31'd0, bus.cout}, 32'd0);
    tick();
    chk("ld_pulse", {31'd0, bus.done}, 32'd0);

    issue(3'b001, 16'hFFFF, 5'd0);
    issue(3'b011, 16'h0000, 5'd0);
`ifdef AC_SAT_EN
    chk("inc_dout", {16'd0, bus.dout}, 32'hFFFF);
    chk("inc_cout", {31'd0, bus.cout}, 32'd1);
`else
    chk("inc_dout", {16'd0, bus.dout}, 32'h0000);
    chk("inc_cout", {31'd0, bus.cout}, 32'd1);
    chk("inc_zero", {31'd0, bus.zero}, 32'd1);
`endif
    chk("inc_done", {31'd0, bus.done}, 32'd1);

    issue(3'b010, 16'h0000, 5'd0);
    chk("clr_dout", {16'd0, bus.dout}, 32'h0000);
    chk("clr_cout", {31'd0, bus.cout}, 32'd0);
    issue(3'b100, 16'h0000, 5'd0);
`ifdef AC_SAT_EN
    chk("dec_dout", {16'd0, bus.dout}, 32'h0000);
`else
    chk("dec_dout", {16'd0, bus.dout}, 32'hFFFF);
`endif
    chk("dec_cout", {31'd0, bus.cout}, 32'd1);

    issue(3'b000, 16'h1234, 5'd0);
`ifdef AC_SAT_EN
    chk("nop_dout", {16'd0, bus.dout}, 32'h0000);
`else
    chk("nop_dout", {16'd0, bus.dout}, 32'hFFFF);
`endif
    chk("nop_cout", {31'd0, bus.cout}, 32'd1);
    chk("nop_done", {31'd0, bus.done}, 32'd1);

    issue(3'b001, 16'h0005, 5'd0);
    issue(3'b011, 16'h0000, 5'd0);
    chk("inc5_dout", {16'd0, bus.dout}, 32'h0006);
    chk("inc5_cout", {31'd0, bus.cout}, 32'd0);
    issue(3'b100, 16'h0000, 5'd0);
    issue(3'b100, 16'h0000, 5'd0);
    chk("dec6_dout", {16'd0, bus.dout}, 32'h0004);
    chk("dec6_cout", {31'd0, bus.cout}, 32'd0);

    issue(3'b001, 16'h8001, 5'd0);
    issue(3'b110, 16'h0000, 5'd3);
    chk("sar_busy1", {31'd0, bus.busy}, 32'd1);
    chk("sar_done1", {31'd0, bus.done}, 32'd0);
    bus.en  = 1'b1;
    bus.op  = 3'b010;
    bus.din = 16'h1234;
    tick();
    bus.en  = 1'b0;
    run_busy(40, nb);
    chk("sar_nbusy", nb, 32'd2);
    chk("sar_done",  {31'd0, bus.done}, 32'd1);
    chk("sar_dout",  {16'd0, bus.dout}, 32'hF000);
    chk("sar_cout",  {31'd0, bus.cout}, 32'd0);
    tick();
    chk("sar_pulse", {31'd0, bus.done}, 32'd0);

    issue(3'b001, 16'h0001, 5'd0);
    issue(3'b111, 16'h0000, 5'd16);
    run_busy(40, nb);
    chk("ror16_nbusy", nb, 32'd16);
    chk("ror16_done",  {31'd0, bus.done}, 32'd1);
    chk("ror16_dout",  {16'd0, bus.dout}, 32'h0001);
    chk("ror16_cout",  {31'd0, bus.cout}, 32'd0);
    issue(3'b111, 16'h0000, 5'd31);
    run_busy(40, nb);
    chk("ror31_nbusy", nb, 32'd16);
    chk("ror31_done",  {31'd0, bus.done}, 32'd1);
    chk("ror31_dout",  {16'd0, bus.dout}, 32'h0001);

    issue(3'b001, 16'h00C3, 5'd0);
    issue(3'b101, 16'h0000, 5'd0);
    chk("shl0_busy", {31'd0, bus.busy}, 32'd0);
    chk("shl0_done", {31'd0, bus.done}, 32'd1);
    chk("shl0_dout", {16'd0, bus.dout}, 32'h00C3);

    issue(3'b001, 16'h0000, 5'd0);
    issue(3'b101, 16'h0000, 5'd4);
    chk("fill_busy", {31'd0, bus.busy}, 32'd1);
    bus.sin = 1'b1;
    tick();
    bus.sin = 1'b0;
    tick();
    chk("fill_mid", {16'd0, bus.dout}, 32'h0002);
    bus.sin = 1'b1;
    tick();
    bus.sin = 1'b1;
    tick();
    bus.sin = 1'b0;
    chk("fill_done", {31'd0, bus.done}, 32'd1);
    chk("fill_busy0", {31'd0, bus.busy}, 32'd0);
    chk("fill_dout", {16'd0, bus.dout}, 32'h000B);
    chk("fill_cout", {31'd0, bus.cout}, 32'd0);

    issue(3'b001, 16'h8000, 5'd0);
    issue(3'b110, 16'h0000, 5'd10);
    tick();
    tick();
    tick();
    tick();
    chk("mid_busy", {31'd0, bus.busy}, 32'd1);
    chk("mid_dout", {16'd0, bus.dout}, 32'hF800);
    chk("mid_neg",  {31'd0, bus.neg},  32'd1);
    chk("mid_zero", {31'd0, bus.zero}, 32'd0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_dout", {16'd0, bus.dout}, 32'h0);
    chk("abort_busy", {31'd0, bus.busy}, 32'd0);
    chk("abort_done", {31'd0, bus.done}, 32'd0);
    chk("abort_cout", {31'd0, bus.cout}, 32'd0);
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("abort_nodone", {31'd0, bus.done}, 32'd0);
    end
    issue(3'b001, 16'h3C3C, 5'd0);
    chk("post_dout", {16'd0, bus.dout}, 32'h3C3C);
    chk("post_done", {31'd0, bus.done}, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/ac_reg_ext.md
Name: ac_reg_ext

Overview:
- Parametrised accumulator register: next generation of the 16-bit enable-load AC.
- Adds width parameter, opcode-driven operations (load, clear, inc, dec) and multi-cycle shift/rotate by a variable amount with busy/done handshake.
- Carry and status flags for the control unit.
- Sits in the processor datapath between the ALU result bus and the operand/memory buses; sequenced by the control unit.

Parameters:
- W, 16, data width in bits (min 4).
- SHW, 5, width of shift-amount port; must satisfy 2^SHW > W.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- en  input  1  operation issue strobe; sampled only when busy=0.
- op  input  3  opcode, sampled with en.
- din  input  W  load data.
- shamt  input  SHW  shift/rotate amount, sampled with en.
- sin  input  1  serial fill bit for shift-left.
- dout  output  W  accumulator contents.
- cout  output  1  registered carry/borrow/last-bit-out.
- zero  output  1  combinational, dout==0.
- neg  output  1  combinational, dout[W-1].
- busy  output  1  multi-cycle shift in progress.
- done  output  1  one-cycle pulse: operation complete.

Behaviour:
- Reset (rst=1 at edge, highest priority, any state): dout=0, cout=0, busy=0, done=0, shift counter=0, state IDLE. Mid-shift reset aborts with no done pulse.
- States: IDLE, SHIFT.
- IDLE, en=0: hold everything; done=0.
- IDLE, en=1, single-cycle ops (result and done=1 in cycle after issue):
  - 000 NOP: dout and cout unchanged; done still pulses.
  - 001 LOAD: dout<=din; cout<=0.
  - 010 CLR: dout<=0; cout<=0.
  - 011 INC: {cout,dout}<=dout+1, modulo 2^W; all-ones wraps to 0 with cout=1.
  - 100 DEC: dout<=dout-1, modulo 2^W; cout<=1 only on borrow (0 wraps to all-ones).
- IDLE, en=1, shift ops, one bit per clock:
  - 101 SHL: each step dout<={dout[W-2:0],sin}; cout<=old dout[W-1].
  - 110 SAR: each step dout<={dout[W-1],dout[W-1:1]}; cout<=old dout[0].
  - 111 ROR: each step dout<={dout[0],dout[W-1:1]}; cout<=old dout[0].
  - Effective count N=min(shamt,W).
- Shift timing, issue in cycle T:
  - N=0: stay IDLE; dout and cout unchanged; done=1 in T+1; busy never asserts.
  - N>0: state SHIFT, counter=N. busy=1 in cycles T+1..T+N; one step at each of those edges.
  - Return to IDLE after edge ending T+N. done=1 and busy=0 in T+N+1; final dout visible there.
- busy and done are never high in the same cycle.
- During SHIFT: en, op, din and shamt are ignored. sin is sampled live at each SHL step.
- Back-to-back: en may be high in the done cycle; a new op issues there.
- done cycle of an op is its first cycle back in IDLE, so a new op never overlaps a pulse it does not own.
- zero and neg always track current dout, including during shifts.

Optional Feature:
- Macro: AC_SAT_EN.
- Defined: INC and DEC saturate.
  - INC at all-ones holds all-ones with cout=1.
  - DEC at 0 holds 0 with cout=1.
  - Otherwise cout=0.
- Undefined: modulo wrap exactly as in Behaviour.
- Shifts, rotates and all timing are identical in both builds.

Test Plan:
- Reset/load: rst=1 for 2 cycles, then LOAD din=16'hA5C3 -> dout=0000 and flags zero=1,neg=0 during reset; dout=A5C3, neg=1, done=1 in next cycle.
- Inc/dec wrap:
  - LOAD FFFF, INC -> dout=0000, cout=1, zero=1.
  - DEC -> dout=FFFF, cout=1.
  - With AC_SAT_EN: INC holds FFFF with cout=1; DEC from 0000 holds 0000 with cout=1.
- Arithmetic shift:
  - LOAD 8001, SAR shamt=3 -> busy high exactly 3 cycles; done in 4th cycle.
  - Result dout=F000, cout=0.
  - en/op pulsed during busy are ignored.
- Rotate/shift bounds:
  - LOAD 0001, ROR shamt=16 -> dout=0001 after 16 busy cycles.
  - ROR shamt=31 clamps to 16, same result.
  - SHL shamt=0 -> no busy; done next cycle; dout unchanged.
- Serial fill: LOAD 0000, SHL shamt=4 with sin=1,0,1,1 on successive busy cycles -> dout=000B, cout=0.
- Reset mid-shift: SAR shamt=10, assert rst on 5th busy cycle -> dout=0, busy=0, no done pulse; next LOAD succeeds normally.
